// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch stage sitting directly behind a combinational instruction memory.
//   Holds the PC and drives two read ports (pc, pc+4). Each cycle it buffers
//   up to two words into a QDEPTH-entry queue. The queue drains to decode at
//   one instruction per cycle over a valid/ready handshake.
//   Fetch begins on start. redirect flushes the queue and refetches from a
//   new address. Fetch stops once HALT_INSTR has been enqueued, and done
//   pulses when the queue has drained.
//
// Ports
//   clock           in   single clock, all state updates on posedge
//   reset           in   synchronous, active-low
//   start           in   begin fetch at start_pc (honoured in IDLE only)
//   start_pc        in   byte address of first instruction
//   redirect_valid  in   flush queue, refetch from redirect_pc
//   redirect_pc     in   redirect target byte address
//   read_addr1      out  imem address: pc
//   read_addr2      out  imem address: pc+4
//   read_instr1     in   imem word at read_addr1 (same cycle)
//   read_instr2     in   imem word at read_addr2 (same cycle)
//   out_valid       out  queue head valid
//   out_ready       in   decode accepts head
//   out_instr       out  head instruction
//   out_pc          out  head instruction byte address
//   busy            out  state != IDLE
//   done            out  one-cycle pulse: halt reached and queue drained
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int                     BITWIDTH   = 32,
    parameter int                     QDEPTH     = 4,
    parameter logic [BITWIDTH-1:0]    HALT_INSTR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [BITWIDTH-1:0] start_pc,
    input  logic                redirect_valid,
    input  logic [BITWIDTH-1:0] redirect_pc,
    output logic [BITWIDTH-1:0] read_addr1,
    output logic [BITWIDTH-1:0] read_addr2,
    input  logic [BITWIDTH-1:0] read_instr1,
    input  logic [BITWIDTH-1:0] read_instr2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_instr,
    output logic [BITWIDTH-1:0] out_pc,
    output logic                busy,
    output logic                done
);

    // state  | meaning
    // IDLE   | waiting for start; queue empty
    // RUN    | fetching up to two words per cycle into the queue
    // STOP   | HALT_INSTR enqueued; no more fetches, draining to decode

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]       QDEPTH_C  = CW'(QDEPTH);
    localparam logic [BITWIDTH-1:0] WORD_BYTES = BITWIDTH'(4);
    localparam logic [BITWIDTH-1:0] ALIGN_MASK = ~BITWIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                done_q, done_d;

    // Queue storage is never reset: head/count gate everything visible.
    logic [BITWIDTH-1:0] instr_q [QDEPTH];
    logic [BITWIDTH-1:0] addr_q  [QDEPTH];

    logic                redirect_act;
    logic                q_nonempty;
    logic                pop;
    logic [CW-1:0]       space;
    logic                fetch_en;
    logic                push1;
    logic                push2;
    logic                halt_hit;
    logic [BITWIDTH-1:0] pc_plus4;
    logic [PW-1:0]       wr1_idx;

    // -----------------------------------------------------------------------
    // Shared datapath terms
    // -----------------------------------------------------------------------
    always_comb begin
        redirect_act = redirect_valid && (state_q != S_IDLE);
        q_nonempty   = (count_q != '0);
        pc_plus4     = pc_q + WORD_BYTES;
        wr1_idx      = tail_q + PW'(1);

        pop   = out_valid && out_ready;
        // A pop this cycle frees its slot for a push in the same cycle.
        space = QDEPTH_C - count_q + CW'(pop);

        fetch_en = (state_q == S_RUN) && !redirect_act;
        push1    = fetch_en && (space != '0);
        // Second word is only taken if the first is not a halt, so
        // nothing past a HALT_INSTR ever enters the queue.
        push2    = fetch_en && (space >= CW'(2)) && (read_instr1 != HALT_INSTR);
        halt_hit = (push1 && (read_instr1 == HALT_INSTR)) ||
                   (push2 && (read_instr2 == HALT_INSTR));
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (redirect_act)  state_d = S_RUN;
                else if (halt_hit) state_d = S_STOP;
            end
            S_STOP: begin
                if (redirect_act)      state_d = S_RUN;
                else if (!q_nonempty)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // done is registered so it lands in the first IDLE cycle.
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = done_q;
        read_addr1 = pc_q;
        read_addr2 = pc_plus4;
        // A redirect kills the head in its own cycle so decode never
        // consumes a wrong-path instruction.
        out_valid  = q_nonempty && !redirect_act;
        out_instr  = q_nonempty ? instr_q[head_q] : '0;
        out_pc     = q_nonempty ? addr_q[head_q]  : '0;
    end

    // -----------------------------------------------------------------------
    // PC and queue pointer next-state
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if ((state_q == S_IDLE) && start) begin
            pc_d = start_pc & ALIGN_MASK;
        end else if (redirect_act) begin
            pc_d    = redirect_pc & ALIGN_MASK;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push2)      pc_d = pc_q + (WORD_BYTES << 1);
            else if (push1) pc_d = pc_plus4;
            head_d  = head_q + PW'(pop);
            tail_d  = tail_q + PW'(push1) + PW'(push2);
            count_d = count_q + CW'(push1) + CW'(push2) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Queue storage writes
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset && push1) begin
            instr_q[tail_q] <= read_instr1;
            addr_q[tail_q]  <= pc_q;
        end
        if (reset && push2) begin
            instr_q[wr1_idx] <= read_instr2;
            addr_q[wr1_idx]  <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] read_addr1, read_addr2;
    logic [31:0] read_instr1, read_instr2;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic        busy, done;

    logic [31:0] mem [256];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    assign read_instr1 = mem[read_addr1[9:2]];
    assign read_instr2 = mem[read_addr2[9:2]];

    instr_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .start_pc       (start_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .read_addr1     (read_addr1),
        .read_addr2     (read_addr2),
        .read_instr1    (read_instr1),
        .read_instr2    (read_instr2),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy),
        .done           (done)
    );

    task automatic next();
        @(negedge clock);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[7]   = 32'h0;
        mem[129] = 32'h0;
        mem[192] = 32'h0;
    endtask

    task automatic do_reset();
        next();
        reset = 1'b0; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        next();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        next();
        reset = 1'b0; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        next(); settle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got=%b exp=0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done got=%b exp=0", done); end
        tests_run++; if (read_addr1 !== 32'h0) begin tests_failed++; $display("FAIL rst_addr1 got=%h exp=0", read_addr1); end
        tests_run++; if (read_addr2 !== 32'h4) begin tests_failed++; $display("FAIL rst_addr2 got=%h exp=4", read_addr2); end
        tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
        tests_run++; if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
        reset = 1'b1;
        // redirect alone in IDLE is ignored
        next();
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        next();
        redirect_valid = 1'b0;
        settle();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_redirect_busy got=%b exp=0", busy); end
        tests_run++; if (read_addr1 !== 32'h0) begin tests_failed++; $display("FAIL idle_redirect_addr got=%h exp=0", read_addr1); end
    endtask

    task automatic test_basic_stream();
        logic [31:0] exp_pc [4];
        logic [31:0] exp_in [4];
        int npop, ndone, first_pop;
        exp_pc[0] = 32'h10; exp_pc[1] = 32'h14; exp_pc[2] = 32'h18; exp_pc[3] = 32'h1C;
        exp_in[0] = 32'hA000_0004; exp_in[1] = 32'hA000_0005; exp_in[2] = 32'hA000_0006; exp_in[3] = 32'h0;
        npop = 0; ndone = 0; first_pop = -1;
        do_reset();
        next();
        start = 1'b1; start_pc = 32'h10; out_ready = 1'b1;
        next();
        start = 1'b0;
        settle();
        tests_run++; if (read_addr1 !== 32'h10) begin tests_failed++; $display("FAIL t1_addr1 got=%h exp=10", read_addr1); end
        tests_run++; if (read_addr2 !== 32'h14) begin tests_failed++; $display("FAIL t1_addr2 got=%h exp=14", read_addr2); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL t1_busy got=%b exp=1", busy); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_valid_c1 got=%b exp=0", out_valid); end
        for (int c = 0; c < 20; c++) begin
            next(); settle();
            if (out_valid && out_ready) begin
                if (first_pop < 0) first_pop = c;
                if (npop < 4) begin
                    tests_run++; if (out_pc !== exp_pc[npop]) begin tests_failed++; $display("FAIL t1_pc[%0d] got=%h exp=%h", npop, out_pc, exp_pc[npop]); end
                    tests_run++; if (out_instr !== exp_in[npop]) begin tests_failed++; $display("FAIL t1_instr[%0d] got=%h exp=%h", npop, out_instr, exp_in[npop]); end
                end
                npop++;
            end
            if (done) begin
                ndone++;
                tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t1_busy_at_done got=%b exp=0", busy); end
            end
        end
        tests_run++; if (first_pop !== 0) begin tests_failed++; $display("FAIL t1_latency got=%0d exp=0", first_pop); end
        tests_run++; if (npop !== 4) begin tests_failed++; $display("FAIL t1_npop got=%0d exp=4", npop); end
        tests_run++; if (ndone !== 1) begin tests_failed++; $display("FAIL t1_ndone got=%0d exp=1", ndone); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        next();
        start = 1'b1; start_pc = 32'h40; out_ready = 1'b0;
        next(); start = 1'b0;
        next(); next(); next(); settle();
        tests_run++; if (read_addr1 !== 32'h50) begin tests_failed++; $display("FAIL t2_pc_full got=%h exp=50", read_addr1); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL t2_valid got=%b exp=1", out_valid); end
        tests_run++; if (out_pc !== 32'h40) begin tests_failed++; $display("FAIL t2_head got=%h exp=40", out_pc); end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            next(); settle();
            tests_run++; if (out_pc !== (32'h40 + 4 * k)) begin tests_failed++; $display("FAIL t2_pop_pc[%0d] got=%h exp=%h", k, out_pc, 32'h40 + 4 * k); end
            tests_run++; if (out_instr !== (32'hA000_0010 + k)) begin tests_failed++; $display("FAIL t2_pop_instr[%0d] got=%h exp=%h", k, out_instr, 32'hA000_0010 + k); end
        end
        next(); settle();
        tests_run++; if (out_pc !== 32'h50) begin tests_failed++; $display("FAIL t2_resume_head got=%h exp=50", out_pc); end
        tests_run++; if (read_addr1 !== 32'h60) begin tests_failed++; $display("FAIL t2_resume_pc got=%h exp=60", read_addr1); end
        out_ready = 1'b0;
    endtask

    task automatic test_partial_space();
        do_reset();
        next();
        start = 1'b1; start_pc = 32'h80; out_ready = 1'b0;
        next(); start = 1'b0;
        next(); out_ready = 1'b1;
        next(); settle();
        tests_run++; if (read_addr1 !== 32'h90) begin tests_failed++; $display("FAIL t3_pc_a got=%h exp=90", read_addr1); end
        tests_run++; if (out_pc !== 32'h84) begin tests_failed++; $display("FAIL t3_head_a got=%h exp=84", out_pc); end
        // count=3 with pop: two words pushed
        next(); out_ready = 1'b0; settle();
        tests_run++; if (read_addr1 !== 32'h98) begin tests_failed++; $display("FAIL t3_cnt3_pop got=%h exp=98", read_addr1); end
        redirect_valid = 1'b1; redirect_pc = 32'hC0;
        next(); redirect_valid = 1'b0; settle();
        tests_run++; if (read_addr1 !== 32'hC0) begin tests_failed++; $display("FAIL t3_redir got=%h exp=c0", read_addr1); end
        next(); out_ready = 1'b1;
        next(); out_ready = 1'b0; settle();
        tests_run++; if (read_addr1 !== 32'hD0) begin tests_failed++; $display("FAIL t3_pc_b got=%h exp=d0", read_addr1); end
        tests_run++; if (out_pc !== 32'hC4) begin tests_failed++; $display("FAIL t3_head_b got=%h exp=c4", out_pc); end
        // count=3 without pop: exactly one word pushed
        next(); settle();
        tests_run++; if (read_addr1 !== 32'hD4) begin tests_failed++; $display("FAIL t3_cnt3_nopop got=%h exp=d4", read_addr1); end
        next(); settle();
        tests_run++; if (read_addr1 !== 32'hD4) begin tests_failed++; $display("FAIL t3_full_hold got=%h exp=d4", read_addr1); end
        tests_run++; if (out_pc !== 32'hC4) begin tests_failed++; $display("FAIL t3_head_c got=%h exp=c4", out_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        next();
        start = 1'b1; start_pc = 32'h100; out_ready = 1'b0;
        next(); start = 1'b0;
        next(); out_ready = 1'b1;
        next();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        settle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t4_valid_kill got=%b exp=0", out_valid); end
        next();
        redirect_valid = 1'b0;
        settle();
        tests_run++; if (read_addr1 !== 32'h40) begin tests_failed++; $display("FAIL t4_addr1 got=%h exp=40", read_addr1); end
        tests_run++; if (read_addr2 !== 32'h44) begin tests_failed++; $display("FAIL t4_addr2 got=%h exp=44", read_addr2); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t4_empty got=%b exp=0", out_valid); end
        next(); settle();
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL t4_valid_new got=%b exp=1", out_valid); end
        tests_run++; if (out_pc !== 32'h40) begin tests_failed++; $display("FAIL t4_first_pc got=%h exp=40", out_pc); end
        tests_run++; if (out_instr !== 32'hA000_0010) begin tests_failed++; $display("FAIL t4_first_instr got=%h exp=a0000010", out_instr); end
        out_ready = 1'b0;
    endtask

    task automatic test_halt();
        // HALT in the second word
        do_reset();
        next();
        start = 1'b1; start_pc = 32'h200; out_ready = 1'b0;
        next(); start = 1'b0;
        next(); settle();
        tests_run++; if (read_addr1 !== 32'h208) begin tests_failed++; $display("FAIL t5a_pc got=%h exp=208", read_addr1); end
        tests_run++; if (out_pc !== 32'h200) begin tests_failed++; $display("FAIL t5a_head got=%h exp=200", out_pc); end
        next(); settle();
        tests_run++; if (read_addr1 !== 32'h208) begin tests_failed++; $display("FAIL t5a_pc_hold got=%h exp=208", read_addr1); end
        out_ready = 1'b1;
        next(); settle();
        tests_run++; if (out_pc !== 32'h204) begin tests_failed++; $display("FAIL t5a_halt_pc got=%h exp=204", out_pc); end
        tests_run++; if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL t5a_halt_instr got=%h exp=0", out_instr); end
        next(); settle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t5a_drained got=%b exp=0", out_valid); end
        next(); settle();
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL t5a_done got=%b exp=1", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t5a_busy got=%b exp=0", busy); end
        // HALT in the first word: only HALT enqueued
        do_reset();
        next();
        start = 1'b1; start_pc = 32'h300; out_ready = 1'b0;
        next(); start = 1'b0;
        next(); settle();
        tests_run++; if (out_pc !== 32'h300) begin tests_failed++; $display("FAIL t5b_head got=%h exp=300", out_pc); end
        tests_run++; if (read_addr1 !== 32'h304) begin tests_failed++; $display("FAIL t5b_pc got=%h exp=304", read_addr1); end
        out_ready = 1'b1;
        next(); settle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t5b_single got=%b exp=0", out_valid); end
        next(); settle();
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL t5b_done got=%b exp=1", done); end
        out_ready = 1'b0;
    endtask

    task automatic test_start_priority();
        do_reset();
        next();
        start = 1'b1; start_pc = 32'h13; redirect_valid = 1'b1; redirect_pc = 32'h80; out_ready = 1'b0;
        next();
        start = 1'b0; redirect_valid = 1'b0;
        settle();
        tests_run++; if (read_addr1 !== 32'h10) begin tests_failed++; $display("FAIL t7_start_wins got=%h exp=10", read_addr1); end
        next();
        start = 1'b1; start_pc = 32'h80;
        next();
        settle();
        tests_run++; if (read_addr1 !== 32'h20) begin tests_failed++; $display("FAIL t7_start_in_run got=%h exp=20", read_addr1); end
        next();
        start = 1'b0;
        settle();
        tests_run++; if (read_addr1 !== 32'h20) begin tests_failed++; $display("FAIL t7_start_in_stop got=%h exp=20", read_addr1); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        next();
        start = 1'b1; start_pc = 32'h100; out_ready = 1'b0;
        next(); start = 1'b0;
        next(); out_ready = 1'b1;
        next();
        reset = 1'b0; start = 1'b1; start_pc = 32'h20; redirect_valid = 1'b1; redirect_pc = 32'h60;
        next();
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
        settle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t6_valid got=%b exp=0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t6_busy got=%b exp=0", busy); end
        tests_run++; if (read_addr1 !== 32'h0) begin tests_failed++; $display("FAIL t6_addr1 got=%h exp=0", read_addr1); end
        tests_run++; if (read_addr2 !== 32'h4) begin tests_failed++; $display("FAIL t6_addr2 got=%h exp=4", read_addr2); end
        next(); settle();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t6_still_idle got=%b exp=0", busy); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t6_still_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    initial begin
        init_mem();
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_partial_space();
        test_redirect();
        test_halt();
        test_start_priority();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
